// File: rtl/sha256_multiblock.sv
// SHA-256 over NUM_OF_WORDS big-endian words from a single-port word memory.
// The block generates its own padding, hashes every block and writes the digest back.
module sha256_multiblock #(
  parameter int unsigned NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned NUM_OF_BLOCKS = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam logic [15:0] NumWords = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LenIdx   = 16'(16 * NUM_OF_BLOCKS - 1);
  localparam logic [31:0] LenBits  = 32'(32 * NUM_OF_WORDS);
  localparam logic [7:0]  LastBlk  = 8'(NUM_OF_BLOCKS - 1);

  localparam logic [31:0] HInit [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    StIdle, StRead, StCompute, StUpdate, StWrite, StDone
  } state_e;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [7:0]  blk_q, blk_d;
  logic [15:0] maddr_q, maddr_d;
  logic [15:0] oaddr_q, oaddr_d;
  logic [31:0] hv_q [8];
  logic [31:0] hv_d [8];
  logic [31:0] s_q [8];   // working variables a..h
  logic [31:0] s_d [8];
  logic [31:0] w_q [16];  // w_q[0] is the schedule word of the current round
  logic [31:0] w_d [16];

  logic [15:0] rd_idx, in_idx;
  logic [31:0] in_word, w_next, t1, t2;

  assign mem_clk = clk;

  assign rd_idx = {4'd0, blk_q, 4'd0} + {9'd0, cnt_q};
  assign in_idx = rd_idx - 16'd1;

  always_comb begin
    if (in_idx < NumWords)       in_word = mem_read_data;
    else if (in_idx == NumWords) in_word = 32'h8000_0000;
    else if (in_idx == LenIdx)   in_word = LenBits;
    else                         in_word = 32'h0;
  end

  assign w_next = (ror(w_q[14], 17) ^ ror(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
                + (ror(w_q[1], 7) ^ ror(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

  assign t1 = s_q[7] + (ror(s_q[4], 6) ^ ror(s_q[4], 11) ^ ror(s_q[4], 25))
            + ((s_q[4] & s_q[5]) ^ (~s_q[4] & s_q[6])) + K[cnt_q[5:0]] + w_q[0];
  assign t2 = (ror(s_q[0], 2) ^ ror(s_q[0], 13) ^ ror(s_q[0], 22))
            + ((s_q[0] & s_q[1]) ^ (s_q[0] & s_q[2]) ^ (s_q[1] & s_q[2]));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    blk_d          = blk_q;
    maddr_d        = maddr_q;
    oaddr_d        = oaddr_q;
    hv_d           = hv_q;
    s_d            = s_q;
    w_d            = w_q;
    done           = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'h0;
    mem_write_data = 32'h0;

    case (state_q)
      StIdle: begin
        if (start) begin
          maddr_d = message_addr;
          oaddr_d = output_addr;
          hv_d    = HInit;
          blk_d   = 8'd0;
          cnt_d   = 7'd0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (cnt_q < 7'd16) mem_addr = maddr_q + rd_idx;
        // Data for the address issued last cycle arrives now.
        if (cnt_q != 7'd0) begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = in_word;
        end
        if (cnt_q == 7'd16) begin
          s_d     = hv_q;
          cnt_d   = 7'd0;
          state_d = StCompute;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StCompute: begin
        s_d[0] = t1 + t2;
        s_d[1] = s_q[0];
        s_d[2] = s_q[1];
        s_d[3] = s_q[2];
        s_d[4] = s_q[3] + t1;
        s_d[5] = s_q[4];
        s_d[6] = s_q[5];
        s_d[7] = s_q[6];
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_next;
        if (cnt_q == 7'd63) begin
          cnt_d   = 7'd0;
          state_d = StUpdate;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StUpdate: begin
        for (int i = 0; i < 8; i++) hv_d[i] = hv_q[i] + s_q[i];
        blk_d   = blk_q + 8'd1;
        cnt_d   = 7'd0;
        state_d = (blk_q == LastBlk) ? StWrite : StRead;
      end
      StWrite: begin
        mem_we         = 1'b1;
        mem_addr       = oaddr_q + {13'd0, cnt_q[2:0]};
        mem_write_data = hv_q[cnt_q[2:0]];
        if (cnt_q == 7'd7) begin
          cnt_d   = 7'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 7'd0;
      blk_q   <= 8'd0;
      maddr_q <= 16'h0;
      oaddr_q <= 16'h0;
      for (int i = 0; i < 8; i++) begin
        hv_q[i] <= 32'h0;
        s_q[i]  <= 32'h0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      maddr_q <= maddr_d;
      oaddr_q <= oaddr_d;
      hv_q    <= hv_d;
      s_q     <= s_d;
      w_q     <= w_d;
    end
  end

endmodule

// File: tb/tb_sha256_multiblock.sv
// Bench for sha256_multiblock: four instances (N=1,20,13,14) on one shared memory,
// table-driven hashes plus held-start and mid-compute reset sequences.
module tb_sha256_multiblock;

  localparam int NDUT = 4;
  localparam int NW [NDUT] = '{1, 20, 13, 14};

  localparam logic [255:0] AbcdDigest =
    256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int          dut;
    logic [15:0] maddr;
    logic [15:0] oaddr;
    int          exp_cyc;
    bit          use_const;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] message_addr, output_addr;
  logic        start_v [NDUT];
  logic        done_v  [NDUT];
  logic        we_v    [NDUT];
  logic        mclk_v  [NDUT];
  logic [15:0] addr_v  [NDUT];
  logic [31:0] wdata_v [NDUT];
  logic [31:0] rdata_v [NDUT];
  logic [31:0] mem [65536];

  int checks = 0;
  int errors = 0;
  int bad_wr = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    sha256_multiblock #(.NUM_OF_WORDS(NW[i])) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start_v[i]),
      .message_addr   (message_addr),
      .output_addr    (output_addr),
      .done           (done_v[i]),
      .mem_clk        (mclk_v[i]),
      .mem_we         (we_v[i]),
      .mem_addr       (addr_v[i]),
      .mem_write_data (wdata_v[i]),
      .mem_read_data  (rdata_v[i])
    );
  end

  // Read port: data one cycle after its address. Writes are applied by the run loop.
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) rdata_v[i] <= mem[addr_v[i]];
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_model(input int n, input logic [15:0] base);
    logic [31:0] hh [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    int nb, gi;
    hh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    nb = (n + 3 + 15) / 16;
    for (int blk = 0; blk < nb; blk++) begin
      for (int t = 0; t < 16; t++) begin
        gi = 16 * blk + t;
        if (gi < n)                w[t] = mem[16'(base + 16'(gi))];
        else if (gi == n)          w[t] = 32'h8000_0000;
        else if (gi == 16*nb - 1)  w[t] = 32'(32 * n);
        else                       w[t] = 32'h0;
      end
      for (int t = 16; t < 64; t++)
        w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
      e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
      hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
    end
    return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_digest(input logic [15:0] oa, input logic [255:0] exp);
    for (int i = 0; i < 8; i++)
      chk($sformatf("digest[%0d]@%h", i, 16'(oa + 16'(i))), mem[16'(oa + 16'(i))],
          exp[255 - 32*i -: 32]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Start a hash on instance k and follow it to its done pulse, applying its writes.
  task automatic run_vec(input int k, input logic [15:0] ma, input logic [15:0] oa,
                         input int exp_cyc, input bit hold);
    int cyc, wcnt, last_we;
    bit seen;
    for (int i = 0; i < 8; i++) mem[16'(oa + 16'(i))] = 32'h0;
    @(negedge clk);
    message_addr = ma;
    output_addr  = oa;
    start_v[k]   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v[k] = 1'b0;
    cyc = 1; wcnt = 0; last_we = -1; seen = 1'b0;
    while (cyc <= 400) begin
      if (we_v[k]) begin
        wcnt++;
        last_we = cyc;
        if (16'(addr_v[k] - oa) > 16'd7) bad_wr++;
        mem[addr_v[k]] = wdata_v[k];
      end
      if (done_v[k]) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("dut%0d done_seen", k), 32'(seen), 32'd1);
    chk($sformatf("dut%0d done_cycle", k), cyc, exp_cyc);
    chk($sformatf("dut%0d write_count", k), wcnt, 32'd8);
    chk($sformatf("dut%0d last_write_cycle", k), last_we, exp_cyc - 1);
    chk($sformatf("dut%0d stray_writes", k), bad_wr, 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("dut%0d done_width", k), 32'(done_v[k]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    logic [255:0] exp;
    int k;

    vecs[0] = '{0, 16'h0100, 16'h0200,  91, 1'b1};
    vecs[1] = '{1, 16'h0000, 16'h0020, 173, 1'b0};
    vecs[2] = '{2, 16'h0300, 16'h0400,  91, 1'b0};
    vecs[3] = '{3, 16'h0500, 16'h0600, 173, 1'b0};
    vecs[4] = '{0, 16'h0100, 16'hFFFC,  91, 1'b1};
    vecs[5] = '{1, 16'hFFF8, 16'h0700, 173, 1'b0};

    reset_n      = 1'b0;
    message_addr = 16'h0;
    output_addr  = 16'h0;
    for (int i = 0; i < NDUT; i++) start_v[i] = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[16'h0100] = 32'h61626364;

    #2;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst dut%0d done", i), 32'(done_v[i]), 32'd0);
      chk($sformatf("rst dut%0d mem_we", i), 32'(we_v[i]), 32'd0);
      chk($sformatf("rst dut%0d mem_addr", i), 32'(addr_v[i]), 32'd0);
      chk($sformatf("rst dut%0d mem_write_data", i), wdata_v[i], 32'd0);
    end
    #5;
    chk("mem_clk follows clk", 32'(mclk_v[0]), 32'(clk));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      k   = vecs[v].dut;
      exp = vecs[v].use_const ? AbcdDigest : sha_model(NW[k], vecs[v].maddr);
      run_vec(k, vecs[v].maddr, vecs[v].oaddr, vecs[v].exp_cyc, 1'b0);
      chk_digest(vecs[v].oaddr, exp);
    end

    // start held high for the whole run: one done, then a fresh hash only from IDLE
    for (int i = 0; i < 20; i++) mem[16'h0800 + 16'(i)] = $urandom;
    exp = sha_model(20, 16'h0800);
    run_vec(1, 16'h0800, 16'h0040, 173, 1'b1);
    chk_digest(16'h0040, exp);
    chk("held start: idle after done", 32'(addr_v[1]), 32'h0);
    @(posedge clk);
    #1;
    chk("held start: restart reads message", 32'(addr_v[1]), 32'h0800);
    chk("held start: no write on restart", 32'(we_v[1]), 32'd0);
    start_v[1] = 1'b0;
    pulse_reset();

    // reset during block 0 COMPUTE, then a clean rerun
    @(negedge clk);
    message_addr = 16'h0500;
    output_addr  = 16'h0600;
    start_v[3]   = 1'b1;
    @(posedge clk);
    #1;
    start_v[3] = 1'b0;
    repeat (39) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid reset mem_we", 32'(we_v[3]), 32'd0);
    chk("mid reset done", 32'(done_v[3]), 32'd0);
    chk("mid reset mem_addr", 32'(addr_v[3]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp = sha_model(14, 16'h0500);
    run_vec(3, 16'h0500, 16'h0600, 173, 1'b0);
    chk_digest(16'h0600, exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
